// File: rtl/call_stack_pkg.sv
// -----------------------------------------------------------------------------
// call_stack_pkg
// Shared types and constants for the return-address stack sequencer.
//   state_e      : sequencer states (IDLE, PUSH, LOAD, FAULT)
//   DEF_PC_WIDTH : default program-counter width
//   DEF_DEPTH    : default number of stack entries
//   depth_width(): bits needed to count 0..entries inclusive
// -----------------------------------------------------------------------------
package call_stack_pkg;

  localparam int DEF_PC_WIDTH = 10;
  localparam int DEF_DEPTH    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    LOAD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // The counter must be able to hold the value "entries" itself (full stack).
  function automatic int depth_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/call_stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// call_stack_ctrl_if
// Bundles every non-clock/reset signal of call_stack_ctrl.
//   master : environment side (decode, interrupt line, stack storage, fetch)
//            drives requests, PC values, stack read data and fault_clr.
//   slave  : the sequencer; drives stack strobes, redirect, acks and status.
// Optional macro CALL_STACK_IRQ_NEST_EN adds the irq_active status signal.
// -----------------------------------------------------------------------------
interface call_stack_ctrl_if
  import call_stack_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int DEPTH    = DEF_DEPTH
);

  localparam int DW = depth_width(DEPTH);

  // requests and operands from decode / interrupt line
  logic                call_req;
  logic                ret_req;
  logic                irq_req;
  logic [PC_WIDTH-1:0] pc_cur;
  logic [PC_WIDTH-1:0] call_target;
  logic [PC_WIDTH-1:0] irq_vector;
  logic                fault_clr;
  // stack storage
  logic [PC_WIDTH-1:0] stk_rdata;
  logic                stk_push;
  logic                stk_pop;
  logic [PC_WIDTH-1:0] stk_wdata;
  // fetch redirect
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_next;
  // acceptance and status
  logic                call_ack;
  logic                ret_ack;
  logic                irq_ack;
  logic                busy;
  logic [DW-1:0]       depth;
  logic                overflow;
  logic                underflow;
`ifdef CALL_STACK_IRQ_NEST_EN
  logic                irq_active;

  modport master (
    output call_req, ret_req, irq_req, pc_cur, call_target, irq_vector,
           fault_clr, stk_rdata,
    input  stk_push, stk_pop, stk_wdata, pc_load, pc_next, call_ack,
           ret_ack, irq_ack, busy, depth, overflow, underflow, irq_active
  );

  modport slave (
    input  call_req, ret_req, irq_req, pc_cur, call_target, irq_vector,
           fault_clr, stk_rdata,
    output stk_push, stk_pop, stk_wdata, pc_load, pc_next, call_ack,
           ret_ack, irq_ack, busy, depth, overflow, underflow, irq_active
  );
`else
  modport master (
    output call_req, ret_req, irq_req, pc_cur, call_target, irq_vector,
           fault_clr, stk_rdata,
    input  stk_push, stk_pop, stk_wdata, pc_load, pc_next, call_ack,
           ret_ack, irq_ack, busy, depth, overflow, underflow
  );

  modport slave (
    input  call_req, ret_req, irq_req, pc_cur, call_target, irq_vector,
           fault_clr, stk_rdata,
    output stk_push, stk_pop, stk_wdata, pc_load, pc_next, call_ack,
           ret_ack, irq_ack, busy, depth, overflow, underflow
  );
`endif

endinterface

// File: rtl/call_stack_ctrl.sv
// -----------------------------------------------------------------------------
// call_stack_ctrl
// Sequencer for the CPU return-address stack. Accepts call / return /
// interrupt-entry requests (priority irq > call > ret, sampled only in IDLE),
// tracks stack depth, strobes the stack and issues a one-cycle fetch redirect.
// Overflow and underflow park the sequencer in FAULT until fault_clr.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : call_stack_ctrl_if.slave (requests, stack strobes, redirect,
//           acks, busy, depth, sticky overflow/underflow flags)
//
// Optional macro CALL_STACK_IRQ_NEST_EN: masks further interrupts while an
// interrupt handler is active and exports irq_active.
//
// Timing:
//   call/irq : accept cycle (ack + push) -> PUSH (depth++) -> LOAD (pc_load)
//   ret      : ack, pop, pc_load and depth-- all in the accepting cycle
// -----------------------------------------------------------------------------
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  call_stack_ctrl_if.slave bus
);

  localparam int            DW   = depth_width(DEPTH);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_e              state_q, state_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                irq_take;

`ifdef CALL_STACK_IRQ_NEST_EN
  logic                irq_active_q, irq_active_d;
  logic [DW-1:0]       isr_depth_q, isr_depth_d;

  // A running handler hides the interrupt line entirely, so a masked irq
  // neither wins arbitration nor can trigger an overflow.
  assign irq_take       = bus.irq_req & ~irq_active_q;
  assign bus.irq_active = irq_active_q;
`else
  assign irq_take = bus.irq_req;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      target_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      target_q    <= target_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef CALL_STACK_IRQ_NEST_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_active_q <= 1'b0;
      isr_depth_q  <= '0;
    end else begin
      irq_active_q <= irq_active_d;
      isr_depth_q  <= isr_depth_d;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    target_d      = target_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
`ifdef CALL_STACK_IRQ_NEST_EN
    irq_active_d  = irq_active_q;
    isr_depth_d   = isr_depth_q;
`endif
    bus.call_ack  = 1'b0;
    bus.ret_ack   = 1'b0;
    bus.irq_ack   = 1'b0;
    bus.stk_push  = 1'b0;
    bus.stk_pop   = 1'b0;
    bus.stk_wdata = '0;
    bus.pc_load   = 1'b0;
    bus.pc_next   = '0;

    // The strobes are combinational from state and requests; keep them quiet
    // while reset is held so a pending request cannot leak an ack or a push.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (irq_take || bus.call_req) begin
            if (depth_q == FULL) begin
              overflow_d = 1'b1;
              state_d    = FAULT;
            end else begin
              bus.stk_push = 1'b1;
              state_d      = PUSH;
              if (irq_take) begin
                // Resume address is the interrupted instruction itself.
                bus.irq_ack   = 1'b1;
                bus.stk_wdata = bus.pc_cur;
                target_d      = bus.irq_vector;
`ifdef CALL_STACK_IRQ_NEST_EN
                irq_active_d  = 1'b1;
                isr_depth_d   = depth_q;
`endif
              end else begin
                bus.call_ack  = 1'b1;
                bus.stk_wdata = bus.pc_cur + PC_WIDTH'(1);
                target_d      = bus.call_target;
              end
            end
          end else if (bus.ret_req) begin
            if (depth_q == '0) begin
              underflow_d = 1'b1;
              state_d     = FAULT;
            end else begin
              bus.ret_ack = 1'b1;
              bus.stk_pop = 1'b1;
              bus.pc_load = 1'b1;
              bus.pc_next = bus.stk_rdata;
              depth_d     = depth_q - DW'(1);
`ifdef CALL_STACK_IRQ_NEST_EN
              // Popping the entry pushed at interrupt entry leaves the handler.
              if (irq_active_q && (depth_q == isr_depth_q + DW'(1))) begin
                irq_active_d = 1'b0;
              end
`endif
            end
          end
        end

        PUSH: begin
          depth_d = depth_q + DW'(1);
          state_d = LOAD;
        end

        LOAD: begin
          bus.pc_load = 1'b1;
          bus.pc_next = target_q;
          state_d     = IDLE;
        end

        FAULT: begin
          if (bus.fault_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            state_d     = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.depth     = depth_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_call_stack_ctrl
// Self-checking bench for call_stack_ctrl. The bench keeps its own model of the
// return-address stack (a queue of pushed addresses), depth and interrupt
// nesting, derived from the sequencer's rules, and also plays the role of the
// stack storage by driving stk_rdata from that model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_call_stack_ctrl;
  import call_stack_pkg::*;

  localparam int PW = 10;
  localparam int D  = 16;
  localparam int DW = depth_width(D);
`ifdef CALL_STACK_IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  // strobe vector order: {irq_ack, call_ack, ret_ack, stk_push, stk_pop, pc_load}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IRQ  = 6'b100100;
  localparam logic [5:0] S_CALL = 6'b010100;
  localparam logic [5:0] S_RET  = 6'b001011;
  localparam logic [5:0] S_LOAD = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  call_stack_ctrl_if #(.PC_WIDTH(PW), .DEPTH(D)) bus();

  call_stack_ctrl #(.PC_WIDTH(PW), .DEPTH(D)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [5:0] strb;
  assign strb = {bus.irq_ack, bus.call_ack, bus.ret_ack, bus.stk_push, bus.stk_pop, bus.pc_load};

  int checks = 0;
  int errors = 0;

  // reference model
  logic [PW-1:0] m_stack[$];
  int            m_act = 0;
  int            m_isr = 0;

  task automatic idle_inputs();
    bus.call_req    = 1'b0;
    bus.ret_req     = 1'b0;
    bus.irq_req     = 1'b0;
    bus.fault_clr   = 1'b0;
    bus.pc_cur      = '0;
    bus.call_target = '0;
    bus.irq_vector  = '0;
    bus.stk_rdata   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.call_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({strb, bus.pc_next, bus.stk_wdata} !== {S_NONE, 10'h000, 10'h000}) begin
      errors++;
      $display("FAIL reset_strobes: got strb=%b pc_next=%h wdata=%h required 000000/000/000", strb, bus.pc_next, bus.stk_wdata);
    end
    checks++;
    if ({bus.depth, bus.busy, bus.overflow, bus.underflow} !== {DW'(0), 3'b000}) begin
      errors++;
      $display("FAIL reset_status: got depth=%0d busy=%b ov=%b un=%b required 0/0/0/0", bus.depth, bus.busy, bus.overflow, bus.underflow);
    end
    @(negedge clk);
    bus.call_req = 1'b0;
    rst = 1'b0;
    $display("txn reset: done");
  endtask

  task automatic test_call_ret();
    @(negedge clk);
    bus.pc_cur = 10'h020; bus.call_target = 10'h100; bus.call_req = 1'b1;
    #1;
    checks++;
    if ({strb, bus.stk_wdata} !== {S_CALL, 10'h021}) begin
      errors++;
      $display("FAIL call_accept: got strb=%b wdata=%h required %b/021", strb, bus.stk_wdata, S_CALL);
    end
    @(negedge clk);
    bus.call_req = 1'b0;
    #1;
    checks++;
    if ({strb, bus.busy, bus.depth} !== {S_NONE, 1'b1, DW'(0)}) begin
      errors++;
      $display("FAIL call_push_cycle: got strb=%b busy=%b depth=%0d required none/1/0", strb, bus.busy, bus.depth);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({strb, bus.pc_next, bus.depth} !== {S_LOAD, 10'h100, DW'(1)}) begin
      errors++;
      $display("FAIL call_redirect: got strb=%b pc_next=%h depth=%0d required %b/100/1", strb, bus.pc_next, bus.depth, S_LOAD);
    end
    m_stack.push_back(10'h021);
    @(negedge clk);
    bus.ret_req = 1'b1; bus.stk_rdata = 10'h021;
    #1;
    checks++;
    if ({strb, bus.pc_next} !== {S_RET, 10'h021}) begin
      errors++;
      $display("FAIL ret_accept: got strb=%b pc_next=%h required %b/021", strb, bus.pc_next, S_RET);
    end
    void'(m_stack.pop_back());
    @(negedge clk);
    bus.ret_req = 1'b0;
    #1;
    checks++;
    if ({bus.depth, bus.busy} !== {DW'(0), 1'b0}) begin
      errors++;
      $display("FAIL ret_depth: got depth=%0d busy=%b required 0/0", bus.depth, bus.busy);
    end
    $display("txn call_ret: call 020->100, ret to 021");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) begin
      logic [PW-1:0] pc;
      pc = PW'(i * 7 + 3);
      @(negedge clk);
      bus.pc_cur = pc; bus.call_target = PW'(i); bus.call_req = 1'b1;
      #1;
      checks++;
      if ({strb, bus.stk_wdata} !== {S_CALL, pc + PW'(1)}) begin
        errors++;
        $display("FAIL fill_call_%0d: got strb=%b wdata=%h required %b/%h", i, strb, bus.stk_wdata, S_CALL, pc + PW'(1));
      end
      m_stack.push_back(pc + PW'(1));
      @(negedge clk);
      bus.call_req = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    bus.call_req = 1'b1;
    #1;
    checks++;
    if (strb !== S_NONE) begin
      errors++;
      $display("FAIL overflow_no_push: got strb=%b required 000000", strb);
    end
    @(negedge clk);
    bus.ret_req = 1'b1;   // requests are ignored while faulted
    #1;
    checks++;
    if ({strb, bus.overflow, bus.underflow, bus.busy, bus.depth} !== {S_NONE, 3'b101, DW'(D)}) begin
      errors++;
      $display("FAIL overflow_flag: got strb=%b ov=%b un=%b busy=%b depth=%0d required none/1/0/1/16", strb, bus.overflow, bus.underflow, bus.busy, bus.depth);
    end
    @(negedge clk);
    bus.call_req = 1'b0; bus.ret_req = 1'b0; bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.overflow, bus.underflow, bus.depth} !== {3'b000, DW'(D)}) begin
      errors++;
      $display("FAIL overflow_clear: got busy=%b ov=%b un=%b depth=%0d required 0/0/0/16", bus.busy, bus.overflow, bus.underflow, bus.depth);
    end
    // unwind back-to-back
    while (m_stack.size() > 0) begin
      @(negedge clk);
      bus.ret_req = 1'b1; bus.stk_rdata = m_stack[$];
      #1;
      checks++;
      if ({strb, bus.pc_next} !== {S_RET, m_stack[$]}) begin
        errors++;
        $display("FAIL unwind_ret: got strb=%b pc_next=%h required %b/%h", strb, bus.pc_next, S_RET, m_stack[$]);
      end
      void'(m_stack.pop_back());
    end
    @(negedge clk);
    bus.ret_req = 1'b0;
    $display("txn overflow: 16 calls, 17th faults, cleared, unwound");
  endtask

  task automatic test_underflow();
    @(negedge clk);
    bus.ret_req = 1'b1;
    #1;
    checks++;
    if (strb !== S_NONE) begin
      errors++;
      $display("FAIL underflow_no_pop: got strb=%b required 000000", strb);
    end
    @(negedge clk);
    bus.ret_req = 1'b0;
    #1;
    checks++;
    if ({bus.underflow, bus.overflow, bus.busy, bus.depth} !== {3'b101, DW'(0)}) begin
      errors++;
      $display("FAIL underflow_flag: got un=%b ov=%b busy=%b depth=%0d required 1/0/1/0", bus.underflow, bus.overflow, bus.busy, bus.depth);
    end
    @(negedge clk);
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.underflow} !== 2'b00) begin
      errors++;
      $display("FAIL underflow_clear: got busy=%b un=%b required 0/0", bus.busy, bus.underflow);
    end
    $display("txn underflow: ret at depth 0 faults, cleared");
  endtask

  task automatic test_priority();
    @(negedge clk);
    bus.pc_cur = 10'h040; bus.irq_vector = 10'h3F0; bus.call_target = 10'h123;
    bus.irq_req = 1'b1; bus.call_req = 1'b1;
    #1;
    checks++;
    if ({strb, bus.stk_wdata} !== {S_IRQ, 10'h040}) begin
      errors++;
      $display("FAIL prio_irq_first: got strb=%b wdata=%h required %b/040", strb, bus.stk_wdata, S_IRQ);
    end
    m_stack.push_back(10'h040);
    m_act = 1; m_isr = 0;
    @(negedge clk);
    bus.irq_req = 1'b0;   // call stays pending
    @(negedge clk);
    #1;
    checks++;
    if ({strb, bus.pc_next} !== {S_LOAD, 10'h3F0}) begin
      errors++;
      $display("FAIL prio_irq_redirect: got strb=%b pc_next=%h required %b/3f0", strb, bus.pc_next, S_LOAD);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({strb, bus.stk_wdata} !== {S_CALL, 10'h041}) begin
      errors++;
      $display("FAIL prio_call_follows: got strb=%b wdata=%h required %b/041", strb, bus.stk_wdata, S_CALL);
    end
    m_stack.push_back(10'h041);
    @(negedge clk);
    bus.call_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({strb, bus.pc_next, bus.depth} !== {S_LOAD, 10'h123, DW'(2)}) begin
      errors++;
      $display("FAIL prio_call_redirect: got strb=%b pc_next=%h depth=%0d required %b/123/2", strb, bus.pc_next, bus.depth, S_LOAD);
    end
    while (m_stack.size() > 0) begin
      @(negedge clk);
      bus.ret_req = 1'b1; bus.stk_rdata = m_stack[$];
      #1;
      checks++;
      if ({strb, bus.pc_next} !== {S_RET, m_stack[$]}) begin
        errors++;
        $display("FAIL prio_unwind: got strb=%b pc_next=%h required %b/%h", strb, bus.pc_next, S_RET, m_stack[$]);
      end
      if (m_act != 0 && m_stack.size() == m_isr + 1) m_act = 0;
      void'(m_stack.pop_back());
    end
    @(negedge clk);
    bus.ret_req = 1'b0;
    $display("txn priority: irq 040->3f0 before call 041->123");
  endtask

`ifdef CALL_STACK_IRQ_NEST_EN
  task automatic test_nest();
    @(negedge clk);
    bus.pc_cur = 10'h050; bus.irq_vector = 10'h200; bus.irq_req = 1'b1;
    #1;
    checks++;
    if (strb !== S_IRQ) begin
      errors++;
      $display("FAIL nest_first_irq: got strb=%b required %b", strb, S_IRQ);
    end
    @(negedge clk);
    bus.irq_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.pc_cur = 10'h200; bus.call_target = 10'h300; bus.call_req = 1'b1;
    #1;
    checks++;
    if ({strb, bus.irq_active} !== {S_CALL, 1'b1}) begin
      errors++;
      $display("FAIL nest_call: got strb=%b irq_active=%b required %b/1", strb, bus.irq_active, S_CALL);
    end
    @(negedge clk);
    bus.call_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.irq_req = 1'b1; bus.irq_vector = 10'h2AA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({strb, bus.busy} !== {S_NONE, 1'b0}) begin
        errors++;
        $display("FAIL nest_masked_%0d: got strb=%b busy=%b required none/0", i, strb, bus.busy);
      end
      @(negedge clk);
    end
    // masked irq must not block a return
    bus.ret_req = 1'b1; bus.stk_rdata = 10'h201;
    #1;
    checks++;
    if ({strb, bus.pc_next} !== {S_RET, 10'h201}) begin
      errors++;
      $display("FAIL nest_ret1: got strb=%b pc_next=%h required %b/201", strb, bus.pc_next, S_RET);
    end
    @(negedge clk);
    bus.stk_rdata = 10'h050;
    #1;
    checks++;
    if ({strb, bus.pc_next, bus.irq_active} !== {S_RET, 10'h050, 1'b1}) begin
      errors++;
      $display("FAIL nest_ret2: got strb=%b pc_next=%h act=%b required %b/050/1", strb, bus.pc_next, bus.irq_active, S_RET);
    end
    @(negedge clk);
    bus.ret_req = 1'b0; bus.pc_cur = 10'h077;
    #1;
    checks++;
    if ({strb, bus.irq_active, bus.stk_wdata} !== {S_IRQ, 1'b0, 10'h077}) begin
      errors++;
      $display("FAIL nest_pending_irq: got strb=%b act=%b wdata=%h required %b/0/077", strb, bus.irq_active, bus.stk_wdata, S_IRQ);
    end
    @(negedge clk);
    bus.irq_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.ret_req = 1'b1; bus.stk_rdata = 10'h077;
    #1;
    checks++;
    if ({strb, bus.irq_active} !== {S_RET, 1'b1}) begin
      errors++;
      $display("FAIL nest_final_ret: got strb=%b act=%b required %b/1", strb, bus.irq_active, S_RET);
    end
    @(negedge clk);
    bus.ret_req = 1'b0;
    #1;
    checks++;
    if ({bus.irq_active, bus.depth} !== {1'b0, DW'(0)}) begin
      errors++;
      $display("FAIL nest_exit: got act=%b depth=%0d required 0/0", bus.irq_active, bus.depth);
    end
    m_act = 0;
    $display("txn nest: second irq masked until handler returns");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int            bias;
      bit            wi, wc, wr, want_push, irq_ok;
      int            kind;   // 0 none, 1 push-type, 2 ret
      logic [PW-1:0] pc, tgt, vec, exp_w, exp_t;
      bias      = ((n / 40) % 2 == 0) ? 75 : 30;
      want_push = ($urandom_range(99) < bias);
      wi        = want_push && ($urandom_range(1) == 1);
      wc        = want_push && (!wi || ($urandom_range(1) == 1));
      wr        = !want_push || ($urandom_range(3) == 0);
      pc  = PW'($urandom);
      tgt = PW'($urandom);
      vec = PW'($urandom);
      irq_ok = wi && !(NEST && m_act != 0);
      kind   = (irq_ok || wc) ? 1 : (wr ? 2 : 0);
      exp_w  = irq_ok ? pc : pc + PW'(1);
      exp_t  = irq_ok ? vec : tgt;

      @(negedge clk);
      bus.irq_req = wi; bus.call_req = wc; bus.ret_req = wr;
      bus.pc_cur = pc; bus.call_target = tgt; bus.irq_vector = vec;
      bus.fault_clr = ($urandom_range(3) == 0);  // no effect outside FAULT
      bus.stk_rdata = (m_stack.size() > 0) ? m_stack[$] : PW'($urandom);
      #1;
      if (kind == 1 && m_stack.size() < D) begin
        checks++;
        if ({strb, bus.stk_wdata} !== {(irq_ok ? S_IRQ : S_CALL), exp_w}) begin
          errors++;
          $display("FAIL rnd_push_accept n=%0d: got strb=%b wdata=%h required %b/%h", n, strb, bus.stk_wdata, (irq_ok ? S_IRQ : S_CALL), exp_w);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        checks++;
        if ({strb, bus.pc_next, bus.depth} !== {S_LOAD, exp_t, DW'(m_stack.size() + 1)}) begin
          errors++;
          $display("FAIL rnd_redirect n=%0d: got strb=%b pc_next=%h depth=%0d required %b/%h/%0d", n, strb, bus.pc_next, bus.depth, S_LOAD, exp_t, m_stack.size() + 1);
        end
        if (irq_ok) begin
          m_act = 1;
          m_isr = m_stack.size();
        end
        m_stack.push_back(exp_w);
        $display("txn rnd %0d: %s push %h -> %h depth %0d", n, irq_ok ? "irq" : "call", exp_w, exp_t, m_stack.size());
      end else if (kind == 2 && m_stack.size() > 0) begin
        checks++;
        if ({strb, bus.pc_next} !== {S_RET, m_stack[$]}) begin
          errors++;
          $display("FAIL rnd_ret n=%0d: got strb=%b pc_next=%h required %b/%h", n, strb, bus.pc_next, S_RET, m_stack[$]);
        end
        if (m_act != 0 && m_stack.size() == m_isr + 1) m_act = 0;
        void'(m_stack.pop_back());
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({bus.depth, bus.busy} !== {DW'(m_stack.size()), 1'b0}) begin
          errors++;
          $display("FAIL rnd_ret_depth n=%0d: got depth=%0d busy=%b required %0d/0", n, bus.depth, bus.busy, m_stack.size());
        end
        $display("txn rnd %0d: ret depth %0d", n, m_stack.size());
      end else if (kind == 0) begin
        checks++;
        if (strb !== S_NONE) begin
          errors++;
          $display("FAIL rnd_masked n=%0d: got strb=%b required 000000", n, strb);
        end
        @(negedge clk);
        idle_inputs();
        $display("txn rnd %0d: masked irq ignored", n);
      end else begin
        // overflow (kind 1, full) or underflow (kind 2, empty)
        checks++;
        if (strb !== S_NONE) begin
          errors++;
          $display("FAIL rnd_fault_accept n=%0d: got strb=%b required 000000", n, strb);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({bus.overflow, bus.underflow, bus.busy, bus.depth} !== {(kind == 1), (kind == 2), 1'b1, DW'(m_stack.size())}) begin
          errors++;
          $display("FAIL rnd_fault_flags n=%0d: got ov=%b un=%b busy=%b depth=%0d required %0d/%0d/1/%0d", n, bus.overflow, bus.underflow, bus.busy, bus.depth, kind == 1, kind == 2, m_stack.size());
        end
        repeat ($urandom_range(2)) @(negedge clk);
        @(negedge clk);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        #1;
        checks++;
        if ({bus.overflow, bus.underflow, bus.busy, bus.depth} !== {3'b000, DW'(m_stack.size())}) begin
          errors++;
          $display("FAIL rnd_fault_clear n=%0d: got ov=%b un=%b busy=%b depth=%0d required 0/0/0/%0d", n, bus.overflow, bus.underflow, bus.busy, bus.depth, m_stack.size());
        end
        $display("txn rnd %0d: %s fault cleared", n, kind == 1 ? "overflow" : "underflow");
      end
`ifdef CALL_STACK_IRQ_NEST_EN
      checks++;
      if (bus.irq_active !== (m_act != 0)) begin
        errors++;
        $display("FAIL rnd_irq_active n=%0d: got %b required %0d", n, bus.irq_active, m_act);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.pc_cur = 10'h003; bus.call_target = 10'h155; bus.call_req = 1'b1;
    #1;
    checks++;
    if ((strb !== S_CALL) && (m_stack.size() < D)) begin
      errors++;
      $display("FAIL mid_accept: got strb=%b required %b", strb, S_CALL);
    end
    @(negedge clk);
    bus.call_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({strb, bus.busy, bus.depth} !== {S_NONE, 1'b0, DW'(0)}) begin
      errors++;
      $display("FAIL mid_reset_abort: got strb=%b busy=%b depth=%0d required none/0/0", strb, bus.busy, bus.depth);
    end
    @(negedge clk);
    rst = 1'b0;
    m_stack.delete();
    m_act = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({strb, bus.busy, bus.depth} !== {S_NONE, 1'b0, DW'(0)}) begin
        errors++;
        $display("FAIL mid_no_redirect_%0d: got strb=%b busy=%b depth=%0d required none/0/0", i, strb, bus.busy, bus.depth);
      end
    end
    $display("txn reset_mid: sequence aborted, no redirect");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
`ifdef CALL_STACK_IRQ_NEST_EN
    test_nest();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
- Sequencer for the CPU's 16-entry return-address stack.
- Accepts call/return/interrupt-entry requests from decode and the interrupt line, and tracks stack depth.
- Drives the stack's push/pop strobes and write data, and issues a one-cycle PC-load redirect to fetch.
- Detects overflow/underflow instead of letting the stack offset wrap silently.

Parameters:
- PC_WIDTH, 10: width of program-counter values.
- DEPTH, 16: number of stack entries; must match the stack instance.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- call_req  in  1  decode requests a call; held until call_ack.
- ret_req  in  1  decode requests a return; held until ret_ack.
- irq_req  in  1  interrupt entry request; level, held until irq_ack.
- pc_cur  in  PC_WIDTH  address of the instruction currently in decode.
- call_target  in  PC_WIDTH  call destination from decode.
- irq_vector  in  PC_WIDTH  interrupt handler address.
- stk_rdata  in  PC_WIDTH  current top-of-stack entry (combinational from stack).
- fault_clr  in  1  clears FAULT state and flags.
- stk_push  out  1  push strobe to stack.
- stk_pop  out  1  pop strobe to stack.
- stk_wdata  out  PC_WIDTH  value to push.
- pc_load  out  1  one-cycle redirect strobe to fetch.
- pc_next  out  PC_WIDTH  redirect address, valid when pc_load=1.
- call_ack / ret_ack / irq_ack  out  1 each  one-cycle acceptance pulses.
- busy  out  1  high in any state other than IDLE.
- depth  out  $clog2(DEPTH+1)  number of live entries, 0..DEPTH.
- overflow / underflow  out  1 each  sticky fault flags.

Behaviour:
- Reset:
  - state = IDLE.
  - depth = 0.
  - All strobes, acks and flags = 0.
  - pc_next and stk_wdata = 0.
- FSM states: IDLE, PUSH, LOAD, FAULT.
- Requests are sampled only in IDLE. Priority is irq > call > ret; losers stay pending and are not acked.
- Call accepted (IDLE, depth < DEPTH):
  - Cycle 0: call_ack=1, stk_push=1, stk_wdata = pc_cur+1 (mod 2^PC_WIDTH), latch call_target, go to PUSH.
  - PUSH: depth++, go to LOAD.
  - LOAD: pc_load=1, pc_next = latched target, go to IDLE.
  - Fetch sees the redirect 2 cycles after acceptance.
- Irq accepted: same sequence as call, except stk_wdata = pc_cur (resume the interrupted instruction) and target = irq_vector.
- Ret accepted (IDLE, depth > 0), all in the same cycle:
  - ret_ack=1, stk_pop=1, pc_load=1, pc_next = stk_rdata, depth--.
  - Stay in IDLE; latency is 1 cycle.
- Overflow: call or irq selected with depth == DEPTH.
  - No push, no ack; overflow=1, go to FAULT.
- Underflow: ret selected with depth == 0.
  - No pop, no ack; underflow=1, go to FAULT.
- FAULT:
  - busy=1; all requests ignored; depth frozen.
  - fault_clr=1 clears both flags and returns to IDLE the next cycle.
  - fault_clr outside FAULT has no effect.
- Mutual exclusion: stk_push and stk_pop are never high in the same cycle, so the stack's reset/default case is never hit.
- Asserting reset mid-sequence (PUSH or LOAD) aborts it. No pc_load is issued, and depth returns to 0.

Optional Feature:
- Macro: CALL_STACK_IRQ_NEST_EN.
- Defined:
  - Irq entry sets irq_active and records isr_depth = depth before the push.
  - irq_req is masked (not acked) while irq_active=1.
  - irq_active clears when a ret is accepted with depth == isr_depth+1.
  - An output irq_active (1 bit) is added.
- Undefined:
  - No masking; irqs nest freely up to DEPTH.
  - The irq_active port is absent.

Decomposition:
- Package call_stack_pkg holds:
  - the state enum type (IDLE, PUSH, LOAD, FAULT);
  - the default PC_WIDTH and DEPTH constants;
  - the depth-width localparam function.
- No sub-module: the FSM and depth counter are a single module; the stack storage stays a separate instance.

Test Plan:
- Reset, then call_req with pc_cur=0x020 and call_target=0x100:
  - Required: stk_push with wdata=0x021, then pc_load with pc_next=0x100 on cycle 2, depth=1.
- Following the above, ret_req with stk_rdata=0x021:
  - Required: same-cycle ret_ack, stk_pop, pc_load, pc_next=0x021; depth=0.
- 16 calls, then a 17th call:
  - Required: no push, overflow=1, busy=1.
  - Then fault_clr=1: IDLE next cycle with depth=16 and flags cleared.
- ret_req at depth=0:
  - Required: underflow=1, no pop, no pc_load.
- irq_req and call_req asserted together, pc_cur=0x040, irq_vector=0x3F0:
  - Required: irq_ack first with push wdata=0x040 and redirect to 0x3F0.
  - call_ack follows afterwards.
- With CALL_STACK_IRQ_NEST_EN defined: irq, then a nested call, then a second irq_req:
  - Required: the second irq is not acked.
  - After two rets, irq_active=0 and the pending irq is accepted.
